// File: rtl/spimem_pkg.sv
// rtl/spimem_pkg.sv - shared widths, state encoding and address helper for the SPI memory prefetcher
package spimem_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEMAND   = 2'd1,
    ST_PREFETCH = 2'd2
  } state_t;

  // Next sequential word address; wraps naturally at the top of the 24-bit space.
  function automatic addr_t next_word(input addr_t a);
    return a + addr_t'(4);
  endfunction

endpackage

// File: rtl/spimem_pf_fifo.sv
// rtl/spimem_pf_fifo.sv - prefetch word buffer with synchronous clear and combinational head word
module spimem_pf_fifo
  import spimem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  data_t                    push_data,
  input  logic                     pop,
  input  logic                     clear,
  output logic [$clog2(DEPTH):0]   count,
  output data_t                    head_data
);

  localparam int PW = $clog2(DEPTH);

  data_t         store [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      store[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head_data = store[rd_ptr];

endmodule

// File: rtl/spimem_prefetch.sv
// rtl/spimem_prefetch.sv - sequential read prefetcher between a CPU port and an SPI flash word reader
module spimem_prefetch
  import spimem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_valid,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              flush,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t        state;
  logic          pf_en;
  logic          killed;
  addr_t         head_addr;
  addr_t         fetch_addr;
  logic [CW-1:0] count;
  data_t         head_data;

  addr_t cpu_word;
  logic  cpu_req, hit, miss, pf_go, push, fifo_clear;
  logic  unused_lo;

  assign unused_lo = ^cpu_addr[1:0];
  assign cpu_word  = {cpu_addr[ADDR_W-1:2], 2'b00};

  // A flush in the same cycle as a request forces the miss path.
  assign cpu_req    = (state == ST_IDLE) && cpu_valid && !cpu_ready;
  assign hit        = cpu_req && !flush && (count != '0) &&
                      (cpu_addr[ADDR_W-1:2] == head_addr[ADDR_W-1:2]);
  assign miss       = cpu_req && !hit;
  assign pf_go      = (state == ST_IDLE) && !cpu_req && pf_en && (count < FULL) && !flush;
  assign push       = (state == ST_PREFETCH) && mem_ready && !killed && !flush;
  assign fifo_clear = flush || miss;

  spimem_pf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (mem_rdata),
    .pop       (hit),
    .clear     (fifo_clear),
    .count     (count),
    .head_data (head_data)
  );

  // killed marks an outstanding fetch whose result must not re-arm prefetching or fill the buffer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      pf_en      <= 1'b0;
      killed     <= 1'b0;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      head_addr  <= '0;
      fetch_addr <= '0;
    end else begin
      cpu_ready <= 1'b0;
      if (flush) begin
        pf_en  <= 1'b0;
        killed <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (hit) begin
            cpu_ready <= 1'b1;
            cpu_rdata <= head_data;
            head_addr <= next_word(head_addr);
          end else if (miss) begin
            mem_valid <= 1'b1;
            mem_addr  <= cpu_word;
            killed    <= 1'b0;
            state     <= ST_DEMAND;
          end else if (pf_go) begin
            mem_valid <= 1'b1;
            mem_addr  <= fetch_addr;
            killed    <= 1'b0;
            state     <= ST_PREFETCH;
          end
        end
        ST_DEMAND: begin
          if (mem_ready) begin
            cpu_ready  <= 1'b1;
            cpu_rdata  <= mem_rdata;
            mem_valid  <= 1'b0;
            fetch_addr <= next_word(mem_addr);
            head_addr  <= next_word(mem_addr);
            if (!killed && !flush) pf_en <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        ST_PREFETCH: begin
          if (mem_ready) begin
            mem_valid  <= 1'b0;
            fetch_addr <= next_word(fetch_addr);
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spimem_prefetch.sv
// tb/tb_spimem_prefetch.sv - directed self-checking bench for spimem_prefetch with a latency-programmable flash responder
module tb_spimem_prefetch;

  logic        clk, resetn;
  logic        cpu_valid, cpu_ready, flush;
  logic [23:0] cpu_addr, mem_addr;
  logic [31:0] cpu_rdata, mem_rdata;
  logic        mem_valid, mem_ready;

  int          n_cmp, n_bad;
  int          lat;
  logic [23:0] mlog[$];
  logic [23:0] resp_addr;

  spimem_prefetch #(.DEPTH(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cpu_valid (cpu_valid),
    .cpu_addr  (cpu_addr),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .flush     (flush),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [23:0] a);
    return {~a[7:0], a};
  endfunction

  // Flash reader model: logs each request, answers after lat cycles unless the request vanished.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_valid === 1'b1 && !mem_ready) begin
        resp_addr = mem_addr;
        mlog.push_back(mem_addr);
        repeat (lat) @(negedge clk);
        if (mem_valid === 1'b1 && resetn) begin
          mem_ready = 1'b1;
          mem_rdata = pat(resp_addr);
          @(negedge clk);
          mem_ready = 1'b0;
          mem_rdata = '0;
        end
      end
    end
  end

  task automatic cpu_read(input logic [23:0] a, input bit with_flush,
                          output logic [31:0] d, output int cyc, output bit mr);
    @(negedge clk);
    cpu_valid = 1'b1;
    cpu_addr  = a;
    if (with_flush) flush = 1'b1;
    cyc = 0;
    d   = 'x;
    mr  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (with_flush) flush = 1'b0;
      cyc++;
      if (cpu_ready) begin
        d  = cpu_rdata;
        mr = mem_ready;
        break;
      end
    end
    cpu_valid = 1'b0;
  endtask

  task automatic wait_settle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (dut.count == 4 && !mem_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mem_valid got %b want 0", mem_valid); end
    n_cmp++; if (cpu_ready !== 1'b0) begin n_bad++; $display("FAIL reset_cpu_ready got %b want 0", cpu_ready); end
    n_cmp++; if (cpu_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_cpu_rdata got %h want 0", cpu_rdata); end
    n_cmp++; if (mem_addr !== 24'h0) begin n_bad++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    n_cmp++; if (dut.count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", dut.count); end
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (mlog.size() != 0) begin n_bad++; $display("FAIL reset_no_prefetch got %0d requests want 0", mlog.size()); end
  endtask

  task automatic test_cold_read();
    logic [31:0] d; int cyc; bit mr, ok;
    logic [23:0] exp_a [5];
    exp_a = '{24'h000100, 24'h000104, 24'h000108, 24'h00010C, 24'h000110};
    lat = 1;
    mlog.delete();
    cpu_read(24'h000100, 1'b0, d, cyc, mr);
    n_cmp++; if (d !== pat(24'h000100)) begin n_bad++; $display("FAIL cold_data got %h want %h", d, pat(24'h000100)); end
    n_cmp++; if (cyc != 3) begin n_bad++; $display("FAIL cold_latency got %0d want 3", cyc); end
    n_cmp++; if (mr !== 1'b1) begin n_bad++; $display("FAIL cold_ready_after_mem_ready got %b want 1", mr); end
    wait_settle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL cold_fill got timeout want count 4"); end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (mlog.size() != 5) begin n_bad++; $display("FAIL cold_req_count got %0d want 5", mlog.size()); end
    for (int i = 0; i < 5 && i < mlog.size(); i++) begin
      n_cmp++; if (mlog[i] !== exp_a[i]) begin n_bad++; $display("FAIL cold_req_addr[%0d] got %h want %h", i, mlog[i], exp_a[i]); end
    end
  endtask

  task automatic test_hits();
    logic [31:0] d; int cyc; bit mr, ok;
    mlog.delete();
    cpu_read(24'h000104, 1'b0, d, cyc, mr);
    n_cmp++; if (d !== pat(24'h000104)) begin n_bad++; $display("FAIL hit104_data got %h want %h", d, pat(24'h000104)); end
    n_cmp++; if (cyc != 1) begin n_bad++; $display("FAIL hit104_latency got %0d want 1", cyc); end
    wait_settle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL hit104_refill got timeout want count 4"); end
    cpu_read(24'h000108, 1'b0, d, cyc, mr);
    n_cmp++; if (d !== pat(24'h000108)) begin n_bad++; $display("FAIL hit108_data got %h want %h", d, pat(24'h000108)); end
    n_cmp++; if (cyc != 1) begin n_bad++; $display("FAIL hit108_latency got %0d want 1", cyc); end
    wait_settle(ok);
    n_cmp++; if (mlog.size() != 2) begin n_bad++; $display("FAIL hit_req_count got %0d want 2", mlog.size()); end
    if (mlog.size() >= 2) begin
      n_cmp++; if (mlog[0] !== 24'h000114) begin n_bad++; $display("FAIL hit_refill0 got %h want 000114", mlog[0]); end
      n_cmp++; if (mlog[1] !== 24'h000118) begin n_bad++; $display("FAIL hit_refill1 got %h want 000118", mlog[1]); end
    end
  endtask

  task automatic test_nonseq_miss();
    logic [31:0] d; int cyc; bit mr, ok;
    logic [23:0] exp_a [6];
    exp_a = '{24'h00011C, 24'h002000, 24'h002004, 24'h002008, 24'h00200C, 24'h002010};
    mlog.delete();
    cpu_read(24'h00010C, 1'b0, d, cyc, mr);
    n_cmp++; if (d !== pat(24'h00010C)) begin n_bad++; $display("FAIL hit10c_data got %h want %h", d, pat(24'h00010C)); end
    cpu_read(24'h002000, 1'b0, d, cyc, mr);
    n_cmp++; if (d !== pat(24'h002000)) begin n_bad++; $display("FAIL nonseq_data got %h want %h", d, pat(24'h002000)); end
    n_cmp++; if (mr !== 1'b1) begin n_bad++; $display("FAIL nonseq_ready_after_mem_ready got %b want 1", mr); end
    wait_settle(ok);
    n_cmp++; if (mlog.size() != 6) begin n_bad++; $display("FAIL nonseq_req_count got %0d want 6", mlog.size()); end
    for (int i = 0; i < 6 && i < mlog.size(); i++) begin
      n_cmp++; if (mlog[i] !== exp_a[i]) begin n_bad++; $display("FAIL nonseq_req_addr[%0d] got %h want %h", i, mlog[i], exp_a[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d; int cyc; bit mr, ok;
    logic [23:0] exp_a [5];
    exp_a = '{24'hFFFFFC, 24'h000000, 24'h000004, 24'h000008, 24'h00000C};
    mlog.delete();
    cpu_read(24'hFFFFFC, 1'b0, d, cyc, mr);
    n_cmp++; if (d !== pat(24'hFFFFFC)) begin n_bad++; $display("FAIL wrap_data got %h want %h", d, pat(24'hFFFFFC)); end
    n_cmp++; if (cyc != 3) begin n_bad++; $display("FAIL wrap_latency got %0d want 3", cyc); end
    wait_settle(ok);
    n_cmp++; if (mlog.size() != 5) begin n_bad++; $display("FAIL wrap_req_count got %0d want 5", mlog.size()); end
    for (int i = 0; i < 5 && i < mlog.size(); i++) begin
      n_cmp++; if (mlog[i] !== exp_a[i]) begin n_bad++; $display("FAIL wrap_req_addr[%0d] got %h want %h", i, mlog[i], exp_a[i]); end
    end
    cpu_read(24'h000001, 1'b0, d, cyc, mr);
    n_cmp++; if (d !== pat(24'h000000)) begin n_bad++; $display("FAIL wrap_hit0_data got %h want %h", d, pat(24'h000000)); end
    n_cmp++; if (cyc != 1) begin n_bad++; $display("FAIL wrap_hit0_latency got %0d want 1", cyc); end
    wait_settle(ok);
  endtask

  task automatic test_flush_hit();
    logic [31:0] d; int cyc; bit mr, ok;
    mlog.delete();
    cpu_read(24'h000004, 1'b1, d, cyc, mr);
    n_cmp++; if (d !== pat(24'h000004)) begin n_bad++; $display("FAIL flushhit_data got %h want %h", d, pat(24'h000004)); end
    n_cmp++; if (cyc != 3) begin n_bad++; $display("FAIL flushhit_latency got %0d want 3", cyc); end
    n_cmp++; if (mlog.size() < 1 || mlog[0] !== 24'h000004) begin n_bad++; $display("FAIL flushhit_miss_addr got %0d requests want first 000004", mlog.size()); end
    wait_settle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL flushhit_refill got timeout want count 4"); end
  endtask

  task automatic test_flush_demand();
    logic [31:0] d; int cyc; bit mr;
    lat = 6;
    mlog.delete();
    fork
      cpu_read(24'h000300, 1'b0, d, cyc, mr);
      begin
        for (int i = 0; i < 50; i++) begin
          if (mem_valid) break;
          @(posedge clk); #1;
        end
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
      end
    join
    n_cmp++; if (d !== pat(24'h000300)) begin n_bad++; $display("FAIL flushdemand_data got %h want %h", d, pat(24'h000300)); end
    n_cmp++; if (cyc != 8) begin n_bad++; $display("FAIL flushdemand_latency got %0d want 8", cyc); end
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (mlog.size() != 1) begin n_bad++; $display("FAIL flushdemand_no_prefetch got %0d requests want 1", mlog.size()); end
    n_cmp++; if (dut.count !== 3'd0) begin n_bad++; $display("FAIL flushdemand_count got %0d want 0", dut.count); end
  endtask

  task automatic test_flush_prefetch();
    logic [31:0] d; int cyc; bit mr, ok;
    lat = 1;
    mlog.delete();
    cpu_read(24'h000100, 1'b0, d, cyc, mr);
    n_cmp++; if (cyc != 3) begin n_bad++; $display("FAIL flushpf_first_latency got %0d want 3", cyc); end
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (dut.count == 1) begin ok = 1'b1; break; end
    end
    lat = 8;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (mem_valid && mem_addr == 24'h000108) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL flushpf_wait_108 got timeout want request 000108"); end
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!mem_valid) break;
      @(posedge clk); #1;
    end
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (dut.count !== 3'd0) begin n_bad++; $display("FAIL flushpf_count got %0d want 0", dut.count); end
    n_cmp++; if (mlog.size() != 3) begin n_bad++; $display("FAIL flushpf_req_count got %0d want 3", mlog.size()); end
    lat = 1;
    cpu_read(24'h000108, 1'b0, d, cyc, mr);
    n_cmp++; if (d !== pat(24'h000108)) begin n_bad++; $display("FAIL flushpf_data got %h want %h", d, pat(24'h000108)); end
    n_cmp++; if (cyc != 3) begin n_bad++; $display("FAIL flushpf_miss_latency got %0d want 3", cyc); end
    n_cmp++; if (mlog.size() < 4 || mlog[3] !== 24'h000108) begin n_bad++; $display("FAIL flushpf_miss_addr got %0d requests want fourth 000108", mlog.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    lat = 8;
    @(negedge clk);
    cpu_valid = 1'b1;
    cpu_addr  = 24'h000500;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (mem_valid && mem_addr == 24'h000500) begin ok = 1'b1; break; end
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_wait_500 got timeout want request 000500"); end
    @(negedge clk);
    resetn    = 1'b0;
    cpu_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_mem_valid got %b want 0", mem_valid); end
    n_cmp++; if (cpu_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_cpu_ready got %b want 0", cpu_ready); end
    n_cmp++; if (dut.count !== 3'd0) begin n_bad++; $display("FAIL rstmid_count got %0d want 0", dut.count); end
    @(negedge clk);
    resetn = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    n_cmp++; if (mem_valid !== 1'b0 || cpu_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_quiet got mem_valid=%b cpu_ready=%b want 0 0", mem_valid, cpu_ready); end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    lat       = 1;
    resetn    = 1'b0;
    cpu_valid = 1'b0;
    cpu_addr  = '0;
    flush     = 1'b0;
    test_reset();
    test_cold_read();
    test_hits();
    test_nonseq_miss();
    test_wrap();
    test_flush_hit();
    test_flush_demand();
    test_flush_prefetch();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spimem_prefetch.md
SPIMEM_PREFETCH -- requirements
Module: spimem_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, prefetch buffer depth in 32-bit words; SHALL be a power of two, 2..8.
REQ-002 clk  in  1  clock; all state SHALL update on rising edge.
REQ-003 resetn  in  1  reset: synchronous, active-low.
REQ-004 cpu_valid  in  1  CPU read request; held high until cpu_ready.
REQ-005 cpu_addr  in  24  CPU byte address; bits [1:0] SHALL be ignored (treated as 0).
REQ-006 cpu_ready  out  1  one-cycle pulse; cpu_rdata valid in the same cycle.
REQ-007 cpu_rdata  out  32  read data to CPU.
REQ-008 flush  in  1  one-cycle pulse invalidating all buffered data.
REQ-009 mem_valid  out  1  request to the downstream SPI flash reader; held until mem_ready.
REQ-010 mem_addr  out  24  word-aligned request address; stable while mem_valid is high.
REQ-011 mem_ready  in  1  one-cycle completion pulse from flash reader.
REQ-012 mem_rdata  in  32  flash word, valid when mem_ready is high.

Function
REQ-013 State machine SHALL have states IDLE, DEMAND (CPU miss fetch outstanding) and PREFETCH (speculative fetch outstanding).
REQ-014 Buffer SHALL hold up to DEPTH consecutive words; head_addr is the oldest entry's address; count is 0..DEPTH.
REQ-015 Hit: in IDLE, cpu_valid high, cpu_ready low, count>0 and cpu_addr[23:2]==head_addr[23:2]; block SHALL pulse cpu_ready with the head word on the next cycle, pop head and advance head_addr by 4.
REQ-016 Miss: in IDLE, cpu_valid high, cpu_ready low, not a hit; block SHALL flush buffer, drive mem_valid=1 and mem_addr=cpu_addr aligned on the next cycle, and enter DEMAND.
REQ-017 DEMAND: on mem_ready, next cycle cpu_ready=1, cpu_rdata=mem_rdata, mem_valid=0; set fetch_addr=mem_addr+4, head_addr=fetch_addr, pf_en=1; return to IDLE.
REQ-018 Prefetch: in IDLE with no qualifying CPU request, pf_en=1 and count<DEPTH, block SHALL issue mem request at fetch_addr and enter PREFETCH.
REQ-019 PREFETCH: on mem_ready, word SHALL be pushed at tail, count+1, fetch_addr+4, return to IDLE; a CPU request arriving meanwhile SHALL wait and then be evaluated as hit/miss.
REQ-020 Push and pop SHALL never occur in the same cycle.
REQ-021 Address arithmetic SHALL wrap modulo 2^24 (0xFFFFFC+4 = 0x000000).
REQ-022 Full (count==DEPTH): no prefetch issued; empty (count==0): every request misses.
REQ-023 cpu_valid SHALL be ignored in any cycle where cpu_ready is high.
REQ-024 Flush: count:=0, pf_en:=0; an outstanding request SHALL complete; PREFETCH data SHALL be discarded; DEMAND data SHALL still be returned to CPU, but pf_en stays 0.
REQ-025 Flush coincident with a hit-qualifying request: flush SHALL win; request is handled as a miss.
REQ-026 mem_valid SHALL never rise while a previous request is still awaiting mem_ready.

Reset
REQ-027 On resetn low: state=IDLE, count=0, pf_en=0, cpu_ready=0, mem_valid=0, cpu_rdata=0, mem_addr=0.
REQ-028 Reset mid-transfer SHALL abandon the request; downstream reader is reset by the same resetn.

Structure
REQ-029 Shared package spimem_pkg SHALL hold ADDR_W=24, DATA_W=32 and the state encoding.
REQ-030 Buffer storage SHALL be sub-module spimem_pf_fifo (push, pop, clear, count, head data); control stays in spimem_prefetch.

Verification
REQ-031 Cold read 0x000100 -> mem_addr=0x000100, cpu_ready one cycle after mem_ready; then prefetch at 0x000104..0x000110 until count=4.
REQ-032 After buffer full, reads 0x000104,0x000108 -> each cpu_ready one cycle after cpu_valid, no mem_valid for them; refill fetch at 0x000114.
REQ-033 Non-sequential read 0x002000 with count=3 -> buffer flushed, mem_addr=0x002000, prefetch restarts at 0x002004.
REQ-034 Read 0xFFFFFC -> prefetch mem_addr=0x000000 (wrap).
REQ-035 Flush during PREFETCH of 0x000108, then read 0x000108 -> discarded word not used; miss issued with mem_addr=0x000108.
REQ-036 resetn low while mem_valid high -> next cycle mem_valid=0, cpu_ready=0, count=0.
